// File: rtl/regfile_access_sequencer_if.sv
// Bus bundle for the register file access sequencer: decode-side instruction
// handshake, register file read/write port, writeback strobe and the operand
// handshake towards execute. "master" is the sequencer side, "slave" is the
// surrounding environment (decode, register file, execute).
interface regfile_access_sequencer_if #(
    parameter int DATA_W = 18,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
);
    // decode -> sequencer
    logic              InValid;
    logic              InReady;
    logic [SEL_W-1:0]  InSrc1;
    logic [SEL_W-1:0]  InSrc2;
    logic              InUsesSrc2;
    logic [SEL_W-1:0]  InDst;
    logic              InWritesDst;
    // register file port
    logic [SEL_W-1:0]  ReadSelect1;
    logic [SEL_W-1:0]  ReadSelect2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [SEL_W-1:0]  WriteSelect;
    logic [DATA_W-1:0] WriteData;
    logic              WriteEnable;
    // writeback from execute
    logic              WbValid;
    logic [SEL_W-1:0]  WbDst;
    logic [DATA_W-1:0] WbData;
    // sequencer -> execute
    logic              OpValid;
    logic              OpReady;
    logic [DATA_W-1:0] OpA;
    logic [DATA_W-1:0] OpB;
    logic [SEL_W-1:0]  OpDst;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        input  InValid, InSrc1, InSrc2, InUsesSrc2, InDst, InWritesDst,
        input  ReadData1, ReadData2,
        input  WbValid, WbDst, WbData,
        input  OpReady,
        output InReady,
        output ReadSelect1, ReadSelect2, WriteSelect, WriteData, WriteEnable,
        output OpValid, OpA, OpB, OpDst, StallCount
    );

    modport slave (
        output InValid, InSrc1, InSrc2, InUsesSrc2, InDst, InWritesDst,
        output ReadData1, ReadData2,
        output WbValid, WbDst, WbData,
        output OpReady,
        input  InReady,
        input  ReadSelect1, ReadSelect2, WriteSelect, WriteData, WriteEnable,
        input  OpValid, OpA, OpB, OpDst, StallCount
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Register file access sequencer between decode and execute.
// Accepts one instruction in IDLE, waits in CHECK until no source register has
// a pending write (scoreboard), captures both operands from the register file
// and presents them to execute in HOLD until accepted. Writebacks are passed
// straight to the register file write port and clear their scoreboard bit.
// Optional feature macro: WB_BYPASS_EN -- forwards a same-cycle writeback to a
// source operand in CHECK, removing the one-cycle stall after the writeback.
module regfile_access_sequencer #(
    parameter int DATA_W = 18,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic Clock,
    input  logic Clear,
    regfile_access_sequencer_if.master bus
);
    localparam int NREGS = 2 ** SEL_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREGS-1:0]  r_sb;
    logic [SEL_W-1:0]  r_src1;
    logic [SEL_W-1:0]  r_src2;
    logic              r_uses2;
    logic [SEL_W-1:0]  r_dst;
    logic              r_writes;
    logic              r_in_ready;
    logic [SEL_W-1:0]  r_rd_sel1;
    logic [SEL_W-1:0]  r_rd_sel2;
    logic              r_op_valid;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [SEL_W-1:0]  r_op_dst;
    logic [CNT_W-1:0]  r_stall;

    logic              w_byp1;
    logic              w_byp2;
    logic              w_pend1;
    logic              w_pend2;
    logic              w_hazard;
    logic              w_issue;
    logic [DATA_W-1:0] w_opnd_a;
    logic [DATA_W-1:0] w_opnd_b;
    logic [NREGS-1:0]  w_sb_clr;
    logic [NREGS-1:0]  w_sb_set;

`ifdef WB_BYPASS_EN
    // A writeback landing this cycle on a source satisfies it immediately.
    assign w_byp1 = bus.WbValid && (bus.WbDst == r_src1);
    assign w_byp2 = bus.WbValid && (bus.WbDst == r_src2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Hazard is judged on the registered scoreboard; Src1==Src2 simply
    // reads the same bit twice, so it is checked once in effect.
    assign w_pend1  = r_sb[r_src1] & ~w_byp1;
    assign w_pend2  = r_uses2 & r_sb[r_src2] & ~w_byp2;
    assign w_hazard = w_pend1 | w_pend2;
    assign w_issue  = (r_state == S_CHECK) && !w_hazard;

    // Forwarded data wins over the register file even when the bit is clear.
    assign w_opnd_a = w_byp1 ? bus.WbData : bus.ReadData1;
    assign w_opnd_b = !r_uses2 ? '0 : (w_byp2 ? bus.WbData : bus.ReadData2);

    // Per-register set/clear requests for the scoreboard.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sb
            assign w_sb_clr[gi] = bus.WbValid && (bus.WbDst == SEL_W'(gi));
            assign w_sb_set[gi] = w_issue && r_writes && (r_dst == SEL_W'(gi));
        end
    endgenerate

    // Scoreboard: writeback clears, issue sets; a same-edge set wins.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
        end
    end

    // Sequencer FSM with registered handshake, read-select and operand outputs.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state    <= S_IDLE;
            r_src1     <= '0;
            r_src2     <= '0;
            r_uses2    <= 1'b0;
            r_dst      <= '0;
            r_writes   <= 1'b0;
            r_in_ready <= 1'b1;
            r_rd_sel1  <= '0;
            r_rd_sel2  <= '0;
            r_op_valid <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_dst   <= '0;
            r_stall    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.InValid) begin
                        r_src1     <= bus.InSrc1;
                        r_src2     <= bus.InSrc2;
                        r_uses2    <= bus.InUsesSrc2;
                        r_dst      <= bus.InDst;
                        r_writes   <= bus.InWritesDst;
                        r_rd_sel1  <= bus.InSrc1;
                        r_rd_sel2  <= bus.InSrc2;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_hazard) begin
                        if (r_stall != {CNT_W{1'b1}}) begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end else begin
                        r_op_a     <= w_opnd_a;
                        r_op_b     <= w_opnd_b;
                        r_op_dst   <= r_dst;
                        r_op_valid <= 1'b1;
                        r_rd_sel1  <= '0;
                        r_rd_sel2  <= '0;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.OpReady) begin
                        r_op_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.InReady     = r_in_ready;
    assign bus.ReadSelect1 = r_rd_sel1;
    assign bus.ReadSelect2 = r_rd_sel2;
    assign bus.WriteSelect = bus.WbDst;
    assign bus.WriteData   = bus.WbData;
    assign bus.WriteEnable = bus.WbValid & ~Clear;
    assign bus.OpValid     = r_op_valid;
    assign bus.OpA         = r_op_a;
    assign bus.OpB         = r_op_b;
    assign bus.OpDst       = r_op_dst;
    assign bus.StallCount  = r_stall;
endmodule
